leitor_serial_registradores: RTL and testbench

Read-side companion to the parallel-load register bank. On a start command it snapshots all bank outputs in one cycle, then streams a selected contiguous range of registers, one word per beat, over a valid/ready interface with index and last flag. It sits between the bank outputs and any serial consumer (debug dump, memory writer, trace port). Bank writes after the snapshot do not affect the stream.

---
 rtl/leitor_serial_registradores.sv | 91 +++++++++
 tb/tb_leitor_serial_registradores.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_serial_registradores.sv
// Snapshot reader for the parallel-load register bank: captures every register on start,
// then streams a contiguous (wrapping) index range over a valid/ready port.
module leitor_serial_registradores #(
  parameter  int LARGURA  = 64,
  parameter  int NUM_REGS = 32,
  localparam int IW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(NUM_REGS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iniciar,
  input  logic [IW-1:0]               end_inicial,
  input  logic [CW-1:0]               quantidade,
  input  logic [NUM_REGS*LARGURA-1:0] regs_in,
  output logic [LARGURA-1:0]          dado_saida,
  output logic [IW-1:0]               indice_saida,
  output logic                        valido,
  input  logic                        pronto,
  output logic                        ultimo,
  output logic                        ocupado,
  output logic                        concluido
);

  typedef enum logic [1:0] {OCIOSO, ENVIANDO, FIM} estado_t;

  estado_t            estado;
  logic [LARGURA-1:0] snap [NUM_REGS];
  logic [CW-1:0]      resta;
  logic [IW-1:0]      indice_prox;

  // indice_saida doubles as the read pointer; power-of-two bank makes the wrap free
  assign indice_prox = indice_saida + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= OCIOSO;
      resta        <= '0;
      dado_saida   <= '0;
      indice_saida <= '0;
      valido       <= 1'b0;
      ultimo       <= 1'b0;
      ocupado      <= 1'b0;
      concluido    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          concluido <= 1'b0;
          if (iniciar) begin
            if (quantidade != '0) begin
              for (int i = 0; i < NUM_REGS; i++) snap[i] <= regs_in[LARGURA*i +: LARGURA];
              // first beat comes straight from the bank so it is visible one cycle after start
              dado_saida   <= regs_in[LARGURA*end_inicial +: LARGURA];
              indice_saida <= end_inicial;
              resta        <= quantidade;
              valido       <= 1'b1;
              ultimo       <= (quantidade == CW'(1));
              ocupado      <= 1'b1;
              estado       <= ENVIANDO;
            end else begin
              concluido <= 1'b1;
              estado    <= FIM;
            end
          end
        end
        ENVIANDO: begin
          if (pronto) begin
            if (resta == CW'(1)) begin
              valido    <= 1'b0;
              ultimo    <= 1'b0;
              ocupado   <= 1'b0;
              concluido <= 1'b1;
              estado    <= FIM;
            end else begin
              dado_saida   <= snap[indice_prox];
              indice_saida <= indice_prox;
              resta        <= resta - CW'(1);
              ultimo       <= (resta == CW'(2));
            end
          end
        end
        FIM: begin
          concluido <= 1'b0;
          estado    <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_serial_registradores.sv
// Directed bench for leitor_serial_registradores with a queue scoreboard of expected beats.
module tb_leitor_serial_registradores;

  localparam int L = 64;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           iniciar;
  logic [4:0]     end_inicial;
  logic [5:0]     quantidade;
  logic [N*L-1:0] regs_in;
  logic [L-1:0]   dado_saida;
  logic [4:0]     indice_saida;
  logic           valido;
  logic           pronto;
  logic           ultimo;
  logic           ocupado;
  logic           concluido;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [N];
  int          tests = 0;
  int          fails = 0;

  leitor_serial_registradores #(.LARGURA(L), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .end_inicial(end_inicial),
    .quantidade(quantidade), .regs_in(regs_in), .dado_saida(dado_saida),
    .indice_saida(indice_saida), .valido(valido), .pronto(pronto),
    .ultimo(ultimo), .ocupado(ocupado), .concluido(concluido)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank();
    for (int i = 0; i < N; i++) begin
      model[i] = 64'h1000 + 64'(i);
      regs_in[L*i +: L] = model[i];
    end
  endtask

  // Drives iniciar for one edge; returns #1 after the sampling edge.
  task automatic start(input int s, input int q);
    exp_t e;
    for (int k = 0; k < q; k++) begin
      e.idx  = 5'((s + k) % N);
      e.data = model[(s + k) % N];
      e.last = (k == q - 1);
      sb.push_back(e);
    end
    iniciar     = 1'b1;
    end_inicial = 5'(s);
    quantidade  = 6'(q);
    tick();
    iniciar = 1'b0;
  endtask

  // mode 0: pronto high; 1: pronto 1,0,0 repeating; 2: random. poke: cycle to pulse iniciar (-1 none)
  task automatic drain(input int mode, input int poke, input int budget);
    int          n = 0;
    logic        got_last = 1'b0;
    logic        held = 1'b0;
    logic [63:0] hd;
    logic [4:0]  hi;
    logic        hu;
    exp_t        e;
    while (!got_last && n < budget) begin
      case (mode)
        0:       pronto = 1'b1;
        1:       pronto = (n % 3 == 0);
        default: pronto = 1'($urandom_range(0, 1));
      endcase
      iniciar = (n == poke);
      if (n == poke) begin
        end_inicial = 5'd17;
        quantidade  = 6'd2;
      end
      @(negedge clk);
      if (n == 0) chk("latency_valido", 64'(valido), 64'd1);
      if (held) begin
        chk("stall_dado", dado_saida, hd);
        chk("stall_indice", 64'(indice_saida), 64'(hi));
        chk("stall_ultimo", 64'(ultimo), 64'(hu));
      end
      held = 1'b0;
      if (valido) begin
        chk("ocupado_beat", 64'(ocupado), 64'd1);
        if (pronto) begin
          if (sb.size() == 0) begin
            chk("extra_beat", 64'(valido), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("beat_indice", 64'(indice_saida), 64'(e.idx));
            chk("beat_dado", dado_saida, e.data);
            chk("beat_ultimo", 64'(ultimo), 64'(e.last));
            got_last = e.last;
          end
        end else begin
          held = 1'b1;
          hd   = dado_saida;
          hi   = indice_saida;
          hu   = ultimo;
        end
      end
      tick();
      n++;
    end
    iniciar = 1'b0;
    pronto  = 1'b1;
    chk("drain_completed", 64'(got_last), 64'd1);
    @(negedge clk);
    chk("concluido_pulse", 64'(concluido), 64'd1);
    chk("valido_after_last", 64'(valido), 64'd0);
    chk("ocupado_after_last", 64'(ocupado), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    tick();
    @(negedge clk);
    chk("concluido_one_cycle", 64'(concluido), 64'd0);
    chk("valido_idle", 64'(valido), 64'd0);
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    iniciar     = 1'b0;
    end_inicial = '0;
    quantidade  = '0;
    pronto      = 1'b1;
    regs_in     = '0;
    load_bank();
    tick();
    tick();
    @(negedge clk);
    chk("rst_valido", 64'(valido), 64'd0);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    chk("rst_concluido", 64'(concluido), 64'd0);
    chk("rst_dado", dado_saida, 64'd0);
    chk("rst_indice", 64'(indice_saida), 64'd0);
    chk("rst_ultimo", 64'(ultimo), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // basic range
    start(3, 4);
    drain(0, -1, 20);

    // wrap-around
    start(30, 4);
    drain(0, -1, 20);

    // full bank with the bank overwritten right after the snapshot
    start(0, 32);
    for (int i = 0; i < N; i++) regs_in[L*i +: L] = 64'hDEAD_BEEF;
    drain(0, -1, 50);
    load_bank();

    // backpressure, plus a start attempt ignored mid-stream
    start(10, 6);
    drain(1, 1, 60);
    start(28, 7);
    drain(2, 2, 120);

    // zero count: pulse only, no beats
    iniciar     = 1'b1;
    end_inicial = 5'd5;
    quantidade  = 6'd0;
    tick();
    iniciar = 1'b0;
    @(negedge clk);
    chk("zero_concluido", 64'(concluido), 64'd1);
    chk("zero_valido", 64'(valido), 64'd0);
    tick();
    @(negedge clk);
    chk("zero_concluido_end", 64'(concluido), 64'd0);
    chk("zero_valido_end", 64'(valido), 64'd0);
    tick();

    // reset during the second of five beats
    start(0, 5);
    pronto = 1'b1;
    @(negedge clk);
    chk("rstmid_beat0_indice", 64'(indice_saida), 64'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_beat1_indice", 64'(indice_saida), 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valido", 64'(valido), 64'd0);
    chk("rstmid_ocupado", 64'(ocupado), 64'd0);
    chk("rstmid_concluido", 64'(concluido), 64'd0);
    chk("rstmid_dado", dado_saida, 64'd0);
    chk("rstmid_indice", 64'(indice_saida), 64'd0);
    chk("rstmid_ultimo", 64'(ultimo), 64'd0);
    sb.delete();
    tick();
    @(negedge clk);
    chk("rstmid_no_pulse", 64'(concluido), 64'd0);
    tick();

    // fresh start after the abandoned transfer
    start(3, 4);
    drain(0, -1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
